// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble, one input
// bit per clock). Feeds packed BCD digits to per-digit seven-segment decoders.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined     -> leading zero digits above digit 0 are output as 4'hF
//                  (decoded downstream as "all segments off").
//   not defined -> plain BCD including leading zeros.
//
// Latency: start accepted at edge S, shifts on S+1..S+WIDTH, done pulse and
// new bcd/overflow after S+WIDTH, back in IDLE after S+WIDTH+1.
// Requires WIDTH >= 2 and DIGITS >= 1.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  // Scratch digit count: log10(2^WIDTH) rounded up, enough for any input.
  localparam int FULL = (WIDTH * 301) / 1000 + 1;
  // Digit count of a zero-extended scratch view wide enough to slice DIGITS.
  localparam int EXT  = (DIGITS > FULL) ? DIGITS : FULL;
  // Bit counter width; holds the value WIDTH.
  localparam int CW   = $clog2(WIDTH + 1);
  // Width of the combined {scratch, shift register} shifted each cycle.
  localparam int CAT  = 4 * FULL + WIDTH;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [WIDTH-1:0]     shreg_q,   shreg_d;
  logic [4*FULL-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [4*DIGITS-1:0]  bcd_q,     bcd_d;
  logic                 ovf_q,     ovf_d;

  // Result of one double-dabble step applied to the current registers.
  logic [4*FULL-1:0]    adj_s;
  logic [CAT-1:0]       cat_s;
  logic [CAT-1:0]       shifted_s;
  logic [4*FULL-1:0]    next_scratch_s;
  logic [WIDTH-1:0]     next_shreg_s;

  // Add 3 to every scratch digit that is 5 or more, so the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [4*FULL-1:0] add3_digits(input logic [4*FULL-1:0] s);
    logic [4*FULL-1:0] r;
    r = s;
    for (int i = 0; i < FULL; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Any nonzero scratch digit at or above index DIGITS means the value
  // does not fit; with DIGITS >= FULL the loop never flags anything.
  function automatic logic digits_overflow(input logic [4*FULL-1:0] s);
    logic o;
    o = 1'b0;
    for (int i = 0; i < FULL; i++) begin
      if ((i >= DIGITS) && (s[4*i +: 4] != 4'd0)) begin
        o = 1'b1;
      end else begin
        o = o;
      end
    end
    return o;
  endfunction

  // Low DIGITS digits of the scratch (value mod 10^DIGITS); digits beyond
  // the scratch width read as zero.
  function automatic logic [4*DIGITS-1:0] truncate_digits(input logic [4*FULL-1:0] s);
    logic [4*EXT-1:0] e;
    e = '0;
    e[4*FULL-1:0] = s;
    return e[4*DIGITS-1:0];
  endfunction

  // Optional leading-zero blanking on the truncated result: walk down from
  // the top digit replacing zeros with 4'hF until the first nonzero digit.
  // Digit 0 is never blanked so a zero value still shows "0".
  function automatic logic [4*DIGITS-1:0] format_digits(input logic [4*DIGITS-1:0] d);
    logic [4*DIGITS-1:0] r;
    logic                lead;
    r    = d;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (BLANK_EN && lead && (d[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // One double-dabble step: adjust digits, then shift {scratch, shreg} left.
  always_comb begin
    adj_s          = add3_digits(scratch_q);
    cat_s          = {adj_s, shreg_q};
    shifted_s      = {cat_s[CAT-2:0], 1'b0};
    next_scratch_s = shifted_s[CAT-1:WIDTH];
    next_shreg_s   = shifted_s[WIDTH-1:0];
  end

  // Next-state and next-output logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        scratch_d = next_scratch_s;
        shreg_d   = next_shreg_s;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last shift: publish the result on the edge entering DONE.
          bcd_d   = format_digits(truncate_digits(next_scratch_s));
          ovf_d   = digits_overflow(next_scratch_s);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        // start is ignored here; no queueing of requests.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= format_digits({(4*DIGITS){1'b0}});
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule
